// File: rtl/axi4_cmd_master.sv
// axi4_cmd_master: single-outstanding AXI4 master that turns
// command/stream requests into INCR bursts.
module axi4_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,

  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,

  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,

  output logic                  done_valid,
  output logic                  done_write,
  output logic [1:0]            done_resp,
  output logic                  done_len_err,

  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,

  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  output logic                  WLAST,
  input  logic                  WREADY,

  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,

  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,

  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  input  logic                  RLAST,
  output logic                  RREADY
);

  localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_WIDTH/8));

  typedef enum logic [2:0] {
    IDLE, AW, W, B, AR, R, DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [7:0]            beat_cnt;
  logic [1:0]            resp_q;
  logic                  write_q;
  logic                  len_err_q;
  logic                  over_q;
  logic                  awvalid_q;
  logic                  arvalid_q;

  logic in_w, in_r, in_b, in_done;
  logic last_beat, w_hs, r_hs;

  assign in_w      = (state == W);
  assign in_r      = (state == R);
  assign in_b      = (state == B);
  assign in_done   = (state == DONE);
  assign last_beat = (beat_cnt == len_q);
  assign w_hs      = in_w & wr_valid & WREADY;
  assign r_hs      = in_r & RVALID & rd_ready;

  assign cmd_ready = (state == IDLE);

  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign AWSIZE  = size_q;
  assign AWVALID = awvalid_q;
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = size_q;
  assign ARVALID = arvalid_q;

  assign WVALID   = in_w & wr_valid;
  assign wr_ready = in_w & WREADY;
  assign WDATA    = in_w ? wr_data : '0;
  assign WLAST    = in_w & last_beat;

  assign BREADY = in_b;

  assign rd_valid = in_r & RVALID;
  assign RREADY   = in_r & rd_ready;
  assign rd_data  = in_r ? RDATA : '0;
  assign rd_last  = in_r & RLAST;

  assign done_valid   = in_done;
  assign done_write   = in_done & write_q;
  assign done_resp    = in_done ? resp_q : 2'b00;
  assign done_len_err = in_done & len_err_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      beat_cnt  <= '0;
      resp_q    <= '0;
      write_q   <= 1'b0;
      len_err_q <= 1'b0;
      over_q    <= 1'b0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr;
            len_q     <= cmd_len;
            size_q    <= cmd_size;
            write_q   <= cmd_write;
            beat_cnt  <= '0;
            resp_q    <= 2'b00;
            len_err_q <= 1'b0;
            over_q    <= 1'b0;
            if (cmd_size > SIZE_MAX) begin
              resp_q <= 2'b10;
              state  <= DONE;
            end else if (cmd_write) begin
              awvalid_q <= 1'b1;
              state     <= AW;
            end else begin
              arvalid_q <= 1'b1;
              state     <= AR;
            end
          end
        end
        AW: begin
          if (AWREADY) begin
            awvalid_q <= 1'b0;
            state     <= W;
          end
        end
        W: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) state <= B;
          end
        end
        B: begin
          if (BVALID) begin
            resp_q <= BRESP;
            state  <= DONE;
          end
        end
        AR: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            state     <= R;
          end
        end
        R: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (RRESP > resp_q) resp_q <= RRESP;
            // over_q survives beat_cnt wrap on very long overruns
            if (over_q || (RLAST && !last_beat)) len_err_q <= 1'b1;
            if (!RLAST && last_beat) over_q <= 1'b1;
            if (RLAST) state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_cmd_master.sv
// tb_axi4_cmd_master: random and directed commands against a
// modelled AXI4 slave, checked by a command-level reference model.
module tb_axi4_cmd_master;

  localparam int DW = 32;
  localparam int AWD = 16;
  localparam int WORDS = 1024;

  logic           ACLK = 1'b0;
  logic           ARESETn;
  logic           cmd_valid, cmd_ready, cmd_write;
  logic [AWD-1:0] cmd_addr;
  logic [7:0]     cmd_len;
  logic [2:0]     cmd_size;
  logic [DW-1:0]  wr_data;
  logic           wr_valid, wr_ready;
  logic [DW-1:0]  rd_data;
  logic           rd_valid, rd_last, rd_ready;
  logic           done_valid, done_write, done_len_err;
  logic [1:0]     done_resp;
  logic [AWD-1:0] AWADDR, ARADDR;
  logic [7:0]     AWLEN, ARLEN;
  logic [2:0]     AWSIZE, ARSIZE;
  logic           AWVALID, AWREADY, ARVALID, ARREADY;
  logic [DW-1:0]  WDATA, RDATA;
  logic           WVALID, WLAST, WREADY;
  logic [1:0]     BRESP, RRESP;
  logic           BVALID, BREADY;
  logic           RVALID, RLAST, RREADY;

  always #5 ACLK = ~ACLK;

  axi4_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .rd_ready(rd_ready),
    .done_valid(done_valid), .done_write(done_write),
    .done_resp(done_resp), .done_len_err(done_len_err),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RLAST(RLAST),
    .RREADY(RREADY)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // slave storage and the reference model's own view of memory
  logic [31:0] smem [WORDS];
  logic [31:0] ref_mem [WORDS];

  logic [31:0] wq[$];
  logic [31:0] got_d[$];
  bit          got_l[$];

  int cyc = 0;
  int aw_delay = 0, aw_wait = 0, rdy_pct = 70, rd_mode = 0;
  int s_awaddr = 0, s_awlen = 0, s_awstep = 4, wbeat = 0, n_w = 0;
  bit w_err = 0, b_pend = 0;
  logic [1:0] b_resp = 2'b00;
  bit r_act = 0, rv_q = 0, wv_q = 0;
  int r_addr = 0, r_step = 4, r_beat = 0, r_total = 0, force_last = -1;
  int n_aw = 0, n_ar = 0, n_done = 0;
  int cmd_cyc = 0, aw_cyc = 0, ar_cyc = 0, b_cyc = 0, r_cyc = 0;
  int done_cyc = 0;
  bit aw_seen = 0, ar_seen = 0, prev_done = 0;
  bit aw_stall = 0, ar_stall = 0;
  int exp_addr = 0, exp_len = 0, exp_size = 0;
  logic d_write, d_lerr, d_cmdrdy;
  logic [1:0] d_resp;

  // slave + client stream model, one pass per cycle at the negedge
  initial begin
    forever begin
      int w;
      @(negedge ACLK);
      cyc++;
      AWREADY = AWVALID && (aw_wait >= aw_delay);
      WREADY  = ($urandom_range(99) < rdy_pct);
      BVALID  = b_pend;
      BRESP   = b_pend ? b_resp : 2'b00;
      ARREADY = ARVALID && ($urandom_range(99) < rdy_pct);
      if (r_act && !rv_q) rv_q = ($urandom_range(99) < rdy_pct);
      w = (r_addr + r_beat * r_step) >> 2;
      RVALID = rv_q;
      RDATA  = (rv_q && w < WORDS) ? smem[w] : 32'h0;
      RRESP  = (rv_q && w >= WORDS) ? 2'b10 : 2'b00;
      RLAST  = rv_q && (r_beat == r_total - 1);
      if (wq.size() > 0 && !wv_q)
        wv_q = ($urandom_range(99) < rdy_pct);
      wr_valid = wv_q;
      wr_data  = (wq.size() > 0) ? wq[0] : 32'h0;
      rd_ready = (rd_mode != 0) ? ~rd_ready
                                : ($urandom_range(99) < rdy_pct);
      #1;
      if (prev_done) chk("done_pulse", done_valid, 0);
      prev_done = done_valid;
      if (done_valid) begin
        n_done++;
        done_cyc = cyc;
        d_write = done_write;
        d_resp = done_resp;
        d_lerr = done_len_err;
        d_cmdrdy = cmd_ready;
      end
      if (AWVALID || ARVALID)
        chk("aw_ar_excl", AWVALID & ARVALID, 0);
      if (aw_stall && ARESETn) chk("aw_hold", AWVALID, 1);
      if (ar_stall && ARESETn) chk("ar_hold", ARVALID, 1);
      aw_stall = AWVALID && !AWREADY;
      ar_stall = ARVALID && !ARREADY;
      if (AWVALID && !aw_seen) begin aw_seen = 1; aw_cyc = cyc; end
      if (ARVALID && !ar_seen) begin ar_seen = 1; ar_cyc = cyc; end
      if (AWVALID && AWREADY) begin
        n_aw++;
        chk("awaddr", AWADDR, exp_addr);
        chk("awlen", AWLEN, exp_len);
        chk("awsize", AWSIZE, exp_size);
        s_awaddr = AWADDR;
        s_awlen = AWLEN;
        s_awstep = 1 << AWSIZE;
        wbeat = 0;
        w_err = 0;
        aw_wait = 0;
      end else if (AWVALID) begin
        aw_wait++;
      end
      if (WVALID && WREADY) begin
        chk("wdata", WDATA, (wq.size() > 0) ? wq[0] : 32'hDEAD);
        chk("wlast", WLAST, wbeat == s_awlen);
        w = (s_awaddr + wbeat * s_awstep) >> 2;
        if (w < WORDS) smem[w] = WDATA;
        else w_err = 1;
        wbeat++;
        n_w++;
        wv_q = 0;
        if (wq.size() > 0) void'(wq.pop_front());
        if (WLAST) begin
          b_pend = 1;
          b_resp = w_err ? 2'b10 : 2'b00;
        end
      end
      if (BVALID && BREADY) begin
        b_pend = 0;
        b_cyc = cyc;
      end
      if (ARVALID && ARREADY) begin
        n_ar++;
        chk("araddr", ARADDR, exp_addr);
        chk("arlen", ARLEN, exp_len);
        chk("arsize", ARSIZE, exp_size);
        r_act = 1;
        r_addr = ARADDR;
        r_step = 1 << ARSIZE;
        r_beat = 0;
        r_total = (force_last >= 0) ? force_last + 1 : ARLEN + 1;
      end
      if (rd_valid && rd_ready) begin
        got_d.push_back(rd_data);
        got_l.push_back(rd_last);
      end
      if (RVALID && RREADY) begin
        r_beat++;
        rv_q = 0;
        if (r_beat == r_total) begin
          r_act = 0;
          r_cyc = cyc;
        end
      end
    end
  end

  task automatic issue(input bit wr, input int addr, input int len,
                       input int size, output bit ok);
    int t;
    @(negedge ACLK);
    cmd_valid = 1;
    cmd_write = wr;
    cmd_addr = addr[AWD-1:0];
    cmd_len = len[7:0];
    cmd_size = size[2:0];
    t = 0;
    #1;
    while (!cmd_ready && t < 50) begin
      @(negedge ACLK);
      #1;
      t++;
    end
    ok = cmd_ready;
    cmd_cyc = cyc;
    @(negedge ACLK);
    cmd_valid = 0;
    if (!ok) chk("cmd_handshake_timeout", 0, 1);
  endtask

  // one command end to end; early>=0 makes the slave end the read burst
  // after beat 'early', dbase>=0 gives write data dbase, dbase+1, ...
  task automatic do_cmd(input bit wr, input int addr, input int len,
                        input int size, input int early, input int dbase);
    int nb, w, t, b_aw, b_ar, b_done;
    logic [1:0] eresp;
    bit elerr, ok;
    logic [31:0] d;
    logic [31:0] ed[$];
    exp_addr = addr;
    exp_len = len;
    exp_size = size;
    force_last = early;
    aw_seen = 0;
    ar_seen = 0;
    got_d.delete();
    got_l.delete();
    b_aw = n_aw;
    b_ar = n_ar;
    b_done = n_done;
    eresp = 2'b00;
    elerr = 0;
    nb = 0;
    if (size > 2) begin
      eresp = 2'b10;
    end else if (wr) begin
      for (int i = 0; i <= len; i++) begin
        d = (dbase >= 0) ? 32'(dbase + i) : $urandom;
        wq.push_back(d);
        w = (addr + i * 4) >> 2;
        if (w < WORDS) ref_mem[w] = d;
        else eresp = 2'b10;
      end
    end else begin
      nb = (early >= 0) ? early + 1 : len + 1;
      for (int i = 0; i < nb; i++) begin
        w = (addr + i * 4) >> 2;
        if (w < WORDS) ed.push_back(ref_mem[w]);
        else begin
          ed.push_back(32'h0);
          eresp = 2'b10;
        end
      end
      elerr = (nb != len + 1);
    end
    issue(wr, addr, len, size, ok);
    if (!ok) return;
    t = 0;
    #2;
    while (n_done == b_done && t < 500) begin
      @(negedge ACLK);
      #2;
      t++;
    end
    chk("done_seen", n_done - b_done, 1);
    chk("done_write", d_write, wr);
    chk("done_resp", d_resp, eresp);
    chk("done_len_err", d_lerr, elerr);
    chk("cmd_ready_in_done", d_cmdrdy, 0);
    if (size > 2) begin
      chk("rej_axi", (n_aw - b_aw) + (n_ar - b_ar) + aw_seen + ar_seen, 0);
      chk("rej_lat", done_cyc - cmd_cyc, 1);
    end else if (wr) begin
      chk("aw_lat", aw_cyc - cmd_cyc, 1);
      chk("b_to_done", done_cyc - b_cyc, 1);
      chk("w_drained", wq.size(), 0);
      chk("wr_no_ar", ar_seen, 0);
    end else begin
      chk("ar_lat", ar_cyc - cmd_cyc, 1);
      chk("rlast_to_done", done_cyc - r_cyc, 1);
      chk("rd_no_aw", aw_seen, 0);
      chk("rd_beats", got_d.size(), nb);
      for (int i = 0; i < nb && i < got_d.size(); i++) begin
        chk("rd_data", got_d[i], ed[i]);
        chk("rd_last", got_l[i], i == nb - 1);
      end
    end
    @(negedge ACLK);
    #1;
    chk("cmd_ready_back", cmd_ready, 1);
    force_last = -1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {AWVALID, ARVALID, WVALID, WLAST, BREADY, RREADY,
              wr_ready, rd_valid, rd_last, done_valid, done_write,
              done_len_err, done_resp}, 0);
    chk({tag, "_addr"}, {AWADDR, ARADDR}, 0);
    chk({tag, "_len"}, {AWLEN, ARLEN, AWSIZE, ARSIZE}, 0);
    chk({tag, "_wdata"}, WDATA, 0);
    chk({tag, "_rdata"}, rd_data, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  task automatic reset_mid_write();
    int t, b_w, b_done;
    bit ok;
    exp_addr = 'h0800;
    exp_len = 3;
    exp_size = 2;
    for (int i = 0; i < 4; i++) wq.push_back(32'hB0 + 32'(i));
    b_w = n_w;
    issue(1, 'h0800, 3, 2, ok);
    if (!ok) return;
    t = 0;
    while (n_w - b_w < 1 && t < 200) begin
      @(negedge ACLK);
      #2;
      t++;
    end
    chk("abort_first_beat", n_w - b_w, 1);
    b_done = n_done;
    @(negedge ACLK);
    #3;
    ARESETn = 0;
    #1;
    chk_reset_outputs("abort_rst");
    wq.delete();
    wv_q = 0;
    b_pend = 0;
    r_act = 0;
    rv_q = 0;
    aw_wait = 0;
    aw_stall = 0;
    ar_stall = 0;
    repeat (3) @(negedge ACLK);
    ARESETn = 1;
    repeat (2) @(negedge ACLK);
    #2;
    chk("abort_no_done", n_done - b_done, 0);
  endtask

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0;
    cmd_len = '0; cmd_size = '0;
    wr_data = '0; wr_valid = 0; rd_ready = 0;
    AWREADY = 0; WREADY = 0; BRESP = '0; BVALID = 0; ARREADY = 0;
    RDATA = '0; RRESP = '0; RVALID = 0; RLAST = 0;
    for (int i = 0; i < WORDS; i++) begin
      smem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    ARESETn = 0;
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(negedge ACLK);
    ARESETn = 1;

    aw_delay = 2;
    do_cmd(1, 'h0010, 3, 2, -1, 'hA0);
    aw_delay = 0;
    rd_mode = 1;
    do_cmd(0, 'h0010, 3, 2, -1, -1);
    rd_mode = 0;
    do_cmd(1, 'h1000, 0, 2, -1, -1);
    do_cmd(0, 'h1000, 1, 2, -1, -1);
    do_cmd(1, 'h0020, 0, 3, -1, -1);
    do_cmd(0, 'h0020, 2, 7, -1, -1);
    do_cmd(0, 'h0010, 3, 2, 1, -1);
    do_cmd(0, 'h0010, 1, 2, 2, -1);
    do_cmd(0, 'h0FF8, 3, 2, -1, -1);
    reset_mid_write();
    do_cmd(1, 'h0040, 0, 2, -1, -1);

    for (int k = 0; k < 40; k++) begin
      int a, l, s;
      bit wr;
      wr = 1'($urandom_range(1));
      l = $urandom_range(7);
      s = ($urandom_range(9) == 0) ? $urandom_range(7, 3) : 2;
      a = ($urandom_range(7) == 0) ? ('h0FF0 + 4 * $urandom_range(3))
                                   : 4 * $urandom_range(255);
      rdy_pct = $urandom_range(90, 30);
      aw_delay = $urandom_range(3);
      do_cmd(wr, a, l, s, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
